// File: rtl/mem_loader_pkg.sv
// Shared state encoding and default widths for the streaming memory loader.
package mem_loader_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_ADDR_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        FINISH = 2'd2
    } state_e;

endpackage

// File: rtl/loader_checksum.sv
// Running modular sum of accepted words, compared against an expected value
// when a load finishes normally. Built only with MEM_LOADER_CHECKSUM_EN.
module loader_checksum #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  load_start,
    input  logic [DATA_WIDTH-1:0] expected_in,
    input  logic                  take,
    input  logic [DATA_WIDTH-1:0] take_data,
    input  logic                  abort_evt,
    input  logic                  finish,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  sum_error
);

    logic [DATA_WIDTH-1:0] expected_q;
    logic                  aborted_q;

    // Aborted loads never raise an error, so remember the abort until the next start.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            expected_q <= '0;
            sum        <= '0;
            sum_error  <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            if (load_start) begin
                expected_q <= expected_in;
                sum        <= '0;
                sum_error  <= 1'b0;
                aborted_q  <= 1'b0;
            end
            if (take) begin
                sum <= DATA_WIDTH'(sum + take_data);
            end
            if (abort_evt) begin
                aborted_q <= 1'b1;
            end
            if (finish && !aborted_q) begin
                sum_error <= (sum != expected_q);
            end
        end
    end

endmodule

// File: rtl/mem_loader.sv
// Copies a block of stream words into a single-port RAM at base_addr.
// Optional checksum ports/logic are enabled with MEM_LOADER_CHECKSUM_EN.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] src_data,
    input  logic                  src_valid,
    output logic                  src_ready,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_write,
    output logic                  busy,
    output logic                  done,
`ifdef MEM_LOADER_CHECKSUM_EN
    input  logic [DATA_WIDTH-1:0] expected_sum,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  sum_error,
`endif
    output logic [LEN_WIDTH-1:0]  count
);

    state_e                state;
    state_e                next_state;
    logic [ADDR_WIDTH-1:0] pointer;
    logic [LEN_WIDTH-1:0]  remaining;
    logic                  handshake;
    logic                  start_acc;

    // Abort wins over a same-cycle handshake by dropping ready.
    assign src_ready = (state == LOAD) && !abort;
    assign handshake = src_valid && src_ready;
    assign start_acc = start && (state == IDLE);

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (length == '0) ? FINISH : LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    next_state = FINISH;
                end else if (handshake && (remaining == LEN_WIDTH'(1))) begin
                    next_state = FINISH;
                end
            end
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Status flags are registered from next_state so they align with the state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            pointer   <= '0;
            remaining <= '0;
            count     <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_write <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= next_state;
            busy      <= (next_state == LOAD);
            done      <= (next_state == FINISH);
            ram_write <= handshake;
            if (start_acc) begin
                pointer   <= base_addr;
                remaining <= length;
                count     <= '0;
            end
            if (handshake) begin
                ram_addr  <= pointer;
                ram_wdata <= src_data;
                pointer   <= ADDR_WIDTH'(pointer + ADDR_WIDTH'(1));
                count     <= LEN_WIDTH'(count + LEN_WIDTH'(1));
                remaining <= LEN_WIDTH'(remaining - LEN_WIDTH'(1));
            end
        end
    end

`ifdef MEM_LOADER_CHECKSUM_EN
    loader_checksum #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_checksum (
        .clock       (clock),
        .reset_n     (reset_n),
        .load_start  (start_acc),
        .expected_in (expected_sum),
        .take        (handshake),
        .take_data   (src_data),
        .abort_evt   ((state == LOAD) && abort),
        .finish      (state == FINISH),
        .sum         (sum),
        .sum_error   (sum_error)
    );
`endif

endmodule

// File: doc/mem_loader.md
Name: mem_loader

Overview:
Parametrised streaming loader that copies a block of words from a valid/ready source (file_reader or any stream producer) into a single-port data memory. Supports a start command with base address and length, backpressure from the source, abort, and busy/done status. It sits between the stimulus/boot source and data_memory and replaces fixed 128-word, free-running loading.

Parameters:
DATA_WIDTH, 8, width of each stream word and RAM data bus
ADDR_WIDTH, 8, RAM address width; depth = 2**ADDR_WIDTH
LEN_WIDTH, ADDR_WIDTH+1, width of the length field, so a full-depth load is encodable

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; accepted only in IDLE
base_addr  in  ADDR_WIDTH  first RAM address, sampled on accepted start
length  in  LEN_WIDTH  number of words to load, sampled on accepted start
abort  in  1  terminates an active load
src_data  in  DATA_WIDTH  stream word
src_valid  in  1  source has a word
src_ready  out  1  loader accepts the word this cycle
ram_addr  out  ADDR_WIDTH  RAM write address (registered)
ram_wdata  out  DATA_WIDTH  RAM write data (registered)
ram_write  out  1  RAM write strobe (registered)
busy  out  1  high in LOAD
done  out  1  one-cycle pulse on completion or abort
count  out  LEN_WIDTH  words written so far in current/last load

Behaviour:
- Reset (reset_n low, async): state IDLE; src_ready, ram_write, busy, done = 0; ram_addr, ram_wdata, count = 0.
- States: IDLE, LOAD, FINISH.
- IDLE: src_ready = 0. start=1 latches base_addr into address pointer, length into remaining, clears count. If length==0 -> FINISH directly (no writes); else -> LOAD.
- LOAD: busy=1; src_ready=1 combinationally from state (no dependency on src_valid). Handshake = src_valid & src_ready. On handshake: ram_wdata<=src_data, ram_addr<=pointer, ram_write<=1 next cycle (1-cycle latency, one word per cycle max); pointer<=pointer+1 modulo 2**ADDR_WIDTH (wraps 0xFF->0x00 for defaults); count+1; remaining-1. Handshake with remaining==1 -> FINISH.
- No handshake cycle: ram_write<=0; ram_addr/ram_wdata hold.
- abort in LOAD -> FINISH immediately; a handshake in the same cycle is not taken (src_ready forced 0 when abort=1); writes already accepted still complete.
- FINISH: one cycle; done=1, busy=0, src_ready=0 -> IDLE. count holds until next accepted start.
- start while busy or in FINISH: ignored.
- Words beyond length are never accepted (src_ready low outside LOAD).
- Reset mid-load: all outputs return to reset values asynchronously; no partial write is issued after reset deasserts.

Optional Feature:
Macro MEM_LOADER_CHECKSUM_EN.
- With: extra ports expected_sum in DATA_WIDTH (sampled on start) and sum_error out 1 plus sum out DATA_WIDTH. sum cleared on start, sum<=sum+src_data (mod 2**DATA_WIDTH) on each handshake; at FINISH after a non-aborted load, sum_error<=(sum!=expected_sum), held until next start; reset 0. Aborted loads leave sum_error 0.
- Without: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package mem_loader_pkg: state encoding (IDLE=2'd0, LOAD=2'd1, FINISH=2'd2), default width constants.
- Optional sub-module loader_checksum (accumulator + compare), instantiated only under the macro. Rest in one module.

Test Plan:
- Reset: hold reset_n low mid-load -> all outputs 0 immediately, state IDLE; after release no ram_write until new start.
- Basic: start base=0x10 length=4, src_valid constant with data 0xA1..0xA4 -> writes at 0x10..0x13 on 4 consecutive cycles, done pulse one cycle after last handshake, count=4.
- Backpressure: src_valid toggled 1,0,1,0 -> ram_write only on cycles following valid handshakes, addresses contiguous, no duplicates.
- Wrap and full depth: base=0xFE length=3 -> addresses 0xFE,0xFF,0x00; base=0 length=256 -> 256 writes, count=256.
- Edge commands: length=0 -> done after one cycle, no writes; start during LOAD ignored; abort after 2 of 5 words -> exactly 2 writes, done pulse, count=2.
- Checksum (macro on): data 0x01,0x02,0xFF with expected_sum=0x02 -> sum_error=0; expected_sum=0x03 -> sum_error=1.
